// File: rtl/s2p_deser.sv
// s2p_deser: serial-to-parallel deserializer.
// Collects W serial bits, MSB first. A one-cycle start strobe marks the
// first bit of each word. The finished word appears on pout together with a
// one-cycle done pulse. Words may arrive back-to-back with no gap.
// All outputs come straight from registers, so no input reaches an output
// combinationally.
//
// Handshake: there is no back-pressure. On each rising edge where start=1,
// the sample on sin is the MSB of a new word; a start of that kind also
// abandons any partial word. done=1 for one cycle means pout was just loaded
// with a complete word. Otherwise pout holds its previous value.
module s2p_deser #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sin,
    output logic [W-1:0] pout,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // state_q stays visible so checkers can bind to the FSM state.
    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [W-1:0]   pout_q,  pout_d;
    logic           done_q,  done_d;

    // Word assembled from the bits held so far plus the bit on this edge.
    logic [W-1:0]   shifted;
    assign shifted = {shreg_q[W-2:0], sin};

    // Register all state. Reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            shreg_q <= '0;
            pout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            pout_q  <= pout_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. In every state, start begins a new word. In SHIFT,
    // the W-th bit completes the word.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shreg_d = shreg_q;
        pout_d  = pout_q;
        done_d  = 1'b0;

        if (start) begin
            // A new MSB arrives. Any partial word is dropped without a done.
            shreg_d = {{(W-1){1'b0}}, sin};
            count_d = CW'(1);
            state_d = SHIFT;
        end else begin
            case (state_q)
                IDLE: begin
                    // No frame is open, so sin is ignored.
                end
                SHIFT: begin
                    shreg_d = shifted;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(W - 1)) begin
                        pout_d  = shifted;
                        done_d  = 1'b1;
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pout = pout_q;
    assign done = done_q;

endmodule

// File: tb/tb_s2p_deser.sv
// Testbench for s2p_deser. A driver applies one (rst, start, sin) triple per
// clock. A reference model collects bits into a queue and pushes each
// finished word into exp_q. A monitor on the falling edge pops exp_q whenever
// done is seen. It also flags a missing or unexpected done, and checks that
// pout holds between completions.
module tb_s2p_deser;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sin;
    logic [W-1:0] pout;
    logic         done;

    s2p_deser #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sin   (sin),
        .pout  (pout),
        .done  (done)
    );

    // Clock and initial input values.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sin   = 1'b0;
    end

    // Reference model and scoreboard.
    logic [W-1:0] exp_q[$];
    bit           bits_q[$];
    logic [W-1:0] model_pout;
    bit           mon_en;
    int           errors;
    int           checks;

    initial begin
        model_pout = '0;
        mon_en     = 1'b0;
        errors     = 0;
        checks     = 0;
    end

    // Model one rising edge from the framing rules: a start opens a new bit
    // list; later bits append; W collected bits form a finished word.
    task automatic model_step(input bit r, input bit s, input bit b);
        logic [W-1:0] word;
        if (r) begin
            bits_q.delete();
            model_pout = '0;
        end else if (s) begin
            bits_q.delete();
            bits_q.push_back(b);
        end else if (bits_q.size() > 0) begin
            bits_q.push_back(b);
            if (bits_q.size() == W) begin
                word = '0;
                for (int i = 0; i < W; i++)
                    word = (word << 1) | W'(bits_q[i]);
                exp_q.push_back(word);
                model_pout = word;
                bits_q.delete();
            end
        end
    endtask

    // Driver: present the inputs, let one rising edge sample them, update the
    // model, then move the inputs away from the edge.
    task automatic step(input bit r, input bit s, input bit b);
        rst   = r;
        start = s;
        sin   = b;
        @(posedge clk);
        model_step(r, s, b);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] val);
        for (int i = W - 1; i >= 0; i--)
            step(1'b0, (i == W - 1), val[i]);
    endtask

    // Monitor: compare the DUT's outputs with the scoreboard on each falling
    // edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [W-1:0] exp_word;
            checks++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1 pout=%h, expected done=0", pout);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (pout !== exp_word) begin
                        errors++;
                        $display("FAIL word: pout=%h expected %h", pout, exp_word);
                    end
                end
            end else begin
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    errors++;
                    $display("FAIL missing_done: done=%b expected done=1 with pout=%h", done, exp_word);
                end
            end
            checks++;
            if (pout !== model_pout) begin
                errors++;
                $display("FAIL pout_hold: pout=%h expected %h", pout, model_pout);
            end
        end
    end

    // Stimulus sequence.
    initial begin
        // Reset: hold for two cycles, then drive sin=1 with no start.
        step(1'b1, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);

        // Single word 4'h6.
        send_word(4'h6);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Back-to-back stream of 16 words with values (i+6) mod 16.
        for (int i = 0; i < 16; i++) send_word(W'((i + 6) % 16));
        step(1'b0, 1'b0, 1'b0);

        // Restart in mid-word: the partial word is dropped, then 4'hB completes.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        send_word(4'hB);
        step(1'b0, 1'b0, 1'b0);

        // Reset in mid-word: no done is produced and pout returns to 0.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);

        // Hold: after 4'h9 completes, toggle sin with no start.
        send_word(4'h9);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, i[0]);

        // Randomized traffic: occasional resets and random start and sin.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end

        // Randomized back-to-back words.
        for (int i = 0; i < 50; i++) send_word(W'($urandom_range(0, (1 << W) - 1)));
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words never seen, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
